// File: rtl/i2c_ack_pkg.sv
// Shared types and constants for the I2C target acknowledge generator.
// Contents: FSM state enum, address/byte widths, byte-counter and bit-counter widths.
package i2c_ack_pkg;

    localparam int unsigned I2C_ADDR_W    = 7;
    localparam int unsigned I2C_BYTE_W    = 8;
    localparam int unsigned I2C_CNT_W     = 8;  // per-transaction written-byte count
    localparam int unsigned I2C_BIT_CNT_W = 4;  // counts 0..8 SCL rises within a byte

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAAck,
        StWr,
        StWAck,
        StRd,
        StRAck,
        StIgnore
    } i2c_state_e;

endpackage

// File: rtl/i2c_ack_gen_if.sv
// Bus/host signal bundle for i2c_ack_gen.
//   scl_in, sda_in, ack_en     : pin and control inputs to the target
//   sda_pull                   : open-drain SDA low enable
//   busy, rw, matched_addr     : addressed-transaction status
//   addr_hit, wr_valid         : one-clock pulses; wr_data holds the last written byte
//   start_det, stop_det        : one-clock bus event pulses
// Modport slave is the target side, master is the pin/host side driving it.
interface i2c_ack_gen_if;
    import i2c_ack_pkg::*;

    logic                  scl_in;
    logic                  sda_in;
    logic                  ack_en;
    logic                  sda_pull;
    logic                  busy;
    logic                  rw;
    logic [I2C_ADDR_W-1:0] matched_addr;
    logic                  addr_hit;
    logic [I2C_BYTE_W-1:0] wr_data;
    logic                  wr_valid;
    logic                  start_det;
    logic                  stop_det;

    modport slave (
        input  scl_in, sda_in, ack_en,
        output sda_pull, busy, rw, matched_addr, addr_hit, wr_data, wr_valid,
               start_det, stop_det
    );

    modport master (
        output scl_in, sda_in, ack_en,
        input  sda_pull, busy, rw, matched_addr, addr_hit, wr_data, wr_valid,
               start_det, stop_det
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Input conditioning for one I2C line: 2-FF synchroniser followed, when the macro
// I2C_ACK_GEN_FILTER_EN is defined, by a FILTER_LEN-clock stability filter.
// Ports: clk, reset_n (async, active low), line_in (raw pin), line_out (conditioned).
// All state resets to 1 so an idle bus is seen after reset.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic line_out
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_in};
        end
    end

`ifdef I2C_ACK_GEN_FILTER_EN
    logic [3:0] cnt_q, cnt_d;
    logic       out_q, out_d;

    // Output follows the input only after it has differed for FILTER_LEN clocks in a row.
    always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (sync_q[1] != out_q) begin
            if (cnt_q == 4'(FILTER_LEN - 1)) begin
                out_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            out_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign line_out = out_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign line_out          = sync_q[1];
`endif

endmodule

// File: rtl/i2c_ack_gen.sv
// I2C target-side acknowledge generator. Tracks START/STOP, shifts in the address
// byte, compares it against DEV_ADDR under ADDR_MASK and drives the ACK slot for
// matching addresses and written data bytes (never for read data). MAX_BYTES limits
// the data bytes ACKed per write transaction (0 = unlimited).
// Ports: clk, reset_n (async, active low), bus (i2c_ack_gen_if.slave).
// Optional build macro: I2C_ACK_GEN_FILTER_EN adds a FILTER_LEN-clock input filter.
module i2c_ack_gen
    import i2c_ack_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR   = 7'h50,
    parameter logic [I2C_ADDR_W-1:0] ADDR_MASK  = 7'h7F,
    parameter int unsigned           MAX_BYTES  = 0,
    parameter int unsigned           FILTER_LEN = 3
) (
    input logic           clk,
    input logic           reset_n,
    i2c_ack_gen_if.slave  bus
);

    localparam logic [I2C_CNT_W-1:0] MaxBytes = I2C_CNT_W'(MAX_BYTES);

    logic scl_s, sda_s, scl_q, sda_q;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_in  (bus.scl_in),
        .line_out (scl_s)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_in  (bus.sda_in),
        .line_out (sda_s)
    );

    i2c_state_e               state_q, state_d;
    logic [I2C_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [I2C_ADDR_W-1:0]    shift_q, shift_d;
    logic [I2C_CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [I2C_ADDR_W-1:0]    addr_q, addr_d;
    logic [I2C_BYTE_W-1:0]    wr_data_q, wr_data_d;
    logic rw_q, rw_d, busy_q, busy_d, sda_pull_q, sda_pull_d;
    logic addr_hit_q, addr_hit_d, wr_valid_q, wr_valid_d;
    logic start_q, start_d, stop_q, stop_d;

    logic scl_rise, scl_fall, start_ev, stop_ev;
    logic last_bit, byte_done, addr_match, under_limit;
    logic [I2C_BYTE_W-1:0] byte_in;

    assign scl_rise    = scl_s & ~scl_q;
    assign scl_fall    = ~scl_s & scl_q;
    assign start_ev    = scl_s & sda_q & ~sda_s;
    assign stop_ev     = scl_s & ~sda_q & sda_s;
    // bit_cnt counts SCL rises in the byte: 7 before the 8th rise, 8 once it is sampled.
    assign last_bit    = (bit_cnt_q == 4'd7);
    assign byte_done   = (bit_cnt_q == 4'd8);
    assign byte_in     = {shift_q, sda_s};
    assign addr_match  = ((shift_q ^ DEV_ADDR) & ADDR_MASK) == '0;
    assign under_limit = (MAX_BYTES == 0) || (byte_cnt_q <= MaxBytes);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        sda_pull_d = sda_pull_q;
        addr_hit_d = 1'b0;
        wr_valid_d = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;

        if (start_ev) begin
            state_d    = StAddr;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            busy_d     = 1'b0;
            sda_pull_d = 1'b0;
            start_d    = 1'b1;
        end else if (stop_ev) begin
            state_d    = StIdle;
            bit_cnt_d  = '0;
            busy_d     = 1'b0;
            sda_pull_d = 1'b0;
            stop_d     = 1'b1;
        end else begin
            if (scl_rise) begin
                shift_d = byte_in[I2C_ADDR_W-1:0];
                if (!byte_done) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end

            unique case (state_q)
                StAddr: begin
                    if (scl_rise && last_bit) begin
                        if (addr_match && bus.ack_en) begin
                            rw_d       = sda_s;
                            addr_d     = shift_q;
                            addr_hit_d = 1'b1;
                            busy_d     = 1'b1;
                        end else begin
                            state_d = StIgnore;
                        end
                    end else if (scl_fall && byte_done) begin
                        state_d    = StAAck;
                        bit_cnt_d  = '0;
                        sda_pull_d = bus.ack_en;
                    end
                end
                StAAck: begin
                    if (scl_fall) begin
                        state_d    = rw_q ? StRd : StWr;
                        bit_cnt_d  = '0;
                        sda_pull_d = 1'b0;
                    end
                end
                StWr: begin
                    if (scl_rise && last_bit) begin
                        wr_data_d  = byte_in;
                        wr_valid_d = 1'b1;
                        if (byte_cnt_q != '1) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        state_d    = StWAck;
                        bit_cnt_d  = '0;
                        sda_pull_d = bus.ack_en && under_limit;
                    end
                end
                StWAck: begin
                    if (scl_fall) begin
                        state_d    = StWr;
                        bit_cnt_d  = '0;
                        sda_pull_d = 1'b0;
                    end
                end
                StRd: begin
                    if (scl_fall && byte_done) begin
                        state_d   = StRAck;
                        bit_cnt_d = '0;
                    end
                end
                StRAck: begin
                    // shift_q[0] holds the master's ACK bit sampled on this slot's rise.
                    if (scl_fall) begin
                        state_d   = shift_q[0] ? StIgnore : StRd;
                        bit_cnt_d = '0;
                    end
                end
                StIdle, StIgnore: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            sda_pull_q <= 1'b0;
            addr_hit_q <= 1'b0;
            wr_valid_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_q      <= scl_s;
            sda_q      <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            sda_pull_q <= sda_pull_d;
            addr_hit_q <= addr_hit_d;
            wr_valid_q <= wr_valid_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign bus.sda_pull     = sda_pull_q;
    assign bus.busy         = busy_q;
    assign bus.rw           = rw_q;
    assign bus.matched_addr = addr_q;
    assign bus.addr_hit     = addr_hit_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.wr_valid     = wr_valid_q;
    assign bus.start_det    = start_q;
    assign bus.stop_det     = stop_q;

endmodule

// File: tb/tb_i2c_ack_gen.sv
// Self-checking bench for i2c_ack_gen. Two targets share one bus:
//   dut0: DEV_ADDR 0x50, ADDR_MASK 0x7F, unlimited bytes
//   dut1: DEV_ADDR 0x50, ADDR_MASK 0x7E, MAX_BYTES 2
// A transaction-level model predicts ACK slots, pulses and status for each.
module tb_i2c_ack_gen;

    localparam int Q = 8;  // clocks per quarter SCL bit

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl = 1'b1;
    logic sda = 1'b1;
    logic ack_en = 1'b1;

    always #5 clk = ~clk;

    i2c_ack_gen_if bus0 ();
    i2c_ack_gen_if bus1 ();

    assign bus0.scl_in = scl;
    assign bus0.sda_in = sda;
    assign bus0.ack_en = ack_en;
    assign bus1.scl_in = scl;
    assign bus1.sda_in = sda;
    assign bus1.ack_en = ack_en;

    i2c_ack_gen #(.DEV_ADDR(7'h50), .ADDR_MASK(7'h7F), .MAX_BYTES(0), .FILTER_LEN(3)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    i2c_ack_gen #(.DEV_ADDR(7'h50), .ADDR_MASK(7'h7E), .MAX_BYTES(2), .FILTER_LEN(3)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    logic [1:0] pull, hit, wv, sdet, pdet, bsy, rwo;
    logic [6:0] maddr [2];
    logic [7:0] wdat [2];

    assign pull = {bus1.sda_pull, bus0.sda_pull};
    assign hit  = {bus1.addr_hit, bus0.addr_hit};
    assign wv   = {bus1.wr_valid, bus0.wr_valid};
    assign sdet = {bus1.start_det, bus0.start_det};
    assign pdet = {bus1.stop_det, bus0.stop_det};
    assign bsy  = {bus1.busy, bus0.busy};
    assign rwo  = {bus1.rw, bus0.rw};
    assign maddr[0] = bus0.matched_addr;
    assign maddr[1] = bus1.matched_addr;
    assign wdat[0]  = bus0.wr_data;
    assign wdat[1]  = bus1.wr_data;

    // Observed pulse counts.
    int hits [2];
    int wvs [2];
    int starts [2];
    int stops [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (hit[d])  hits[d]   <= hits[d] + 1;
            if (wv[d])   wvs[d]    <= wvs[d] + 1;
            if (sdet[d]) starts[d] <= starts[d] + 1;
            if (pdet[d]) stops[d]  <= stops[d] + 1;
        end
    end

    // Reference model state.
    int         e_hits [2];
    int         e_wvs [2];
    int         e_starts [2];
    int         e_stops [2];
    logic [7:0] e_wr [2];
    logic [6:0] e_maddr [2];
    logic       e_rw [2];
    logic       e_busy [2];
    int         mode [2];  // 0 idle/ignored, 1 writing, 2 reading, 3 expecting address
    int         cnt [2];
    logic [6:0] m_mask [2];
    int         m_max [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_wr[d] = 8'h00;
            e_maddr[d] = 7'h00;
            e_rw[d] = 1'b0;
            e_busy[d] = 1'b0;
            mode[d] = 0;
            cnt[d] = 0;
        end
    endtask

    // One SCL bit; pull is checked in the middle of the high phase.
    task automatic bit_out(input logic b, input logic [1:0] exp_pull, input string tag);
        wclk(Q);
        sda = b;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        for (int d = 0; d < 2; d++) check_eq($sformatf("%s/pull%0d", tag, d), pull[d], exp_pull[d]);
        wclk(Q);
        scl = 1'b0;
    endtask

    task automatic check_all(input string tag);
        wclk(4);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s/hits%0d", tag, d), hits[d], e_hits[d]);
            check_eq($sformatf("%s/wvalid%0d", tag, d), wvs[d], e_wvs[d]);
            check_eq($sformatf("%s/starts%0d", tag, d), starts[d], e_starts[d]);
            check_eq($sformatf("%s/stops%0d", tag, d), stops[d], e_stops[d]);
            check_eq($sformatf("%s/busy%0d", tag, d), bsy[d], e_busy[d]);
            check_eq($sformatf("%s/rw%0d", tag, d), rwo[d], e_rw[d]);
            check_eq($sformatf("%s/maddr%0d", tag, d), maddr[d], e_maddr[d]);
            check_eq($sformatf("%s/wdata%0d", tag, d), wdat[d], e_wr[d]);
        end
    endtask

    task automatic do_start();
        if (scl == 1'b0) begin
            wclk(Q);
            sda = 1'b1;
            wclk(Q);
            scl = 1'b1;
        end
        wclk(Q);
        sda = 1'b0;
        wclk(Q);
        scl = 1'b0;
        for (int d = 0; d < 2; d++) begin
            e_starts[d]++;
            e_busy[d] = 1'b0;
            mode[d] = 3;
            cnt[d] = 0;
        end
    endtask

    task automatic do_stop(input string tag);
        wclk(Q);
        sda = 1'b0;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        sda = 1'b1;
        wclk(Q);
        for (int d = 0; d < 2; d++) begin
            e_stops[d]++;
            e_busy[d] = 1'b0;
            mode[d] = 0;
        end
        check_all(tag);
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic r, output logic [1:0] ep);
        logic [7:0] b;
        b = {a, r};
        for (int i = 7; i >= 0; i--) bit_out(b[i], 2'b00, "abit");
        for (int d = 0; d < 2; d++) begin
            ep[d] = (((a ^ 7'h50) & m_mask[d]) == 7'h00) && ack_en;
            if (ep[d]) begin
                e_hits[d]++;
                e_rw[d] = r;
                e_maddr[d] = a;
                e_busy[d] = 1'b1;
                mode[d] = r ? 2 : 1;
            end else begin
                mode[d] = 0;
            end
        end
    endtask

    task automatic send_addr(input logic [6:0] a, input logic r);
        logic [1:0] ep;
        addr_phase(a, r, ep);
        bit_out(1'b1, ep, "aack");
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("addr/busy%0d", d), bsy[d], e_busy[d]);
            check_eq($sformatf("addr/rw%0d", d), rwo[d], e_rw[d]);
            check_eq($sformatf("addr/maddr%0d", d), maddr[d], e_maddr[d]);
        end
    endtask

    task automatic send_data(input logic [7:0] v);
        logic [1:0] ep;
        for (int i = 7; i >= 0; i--) bit_out(v[i], 2'b00, "wbit");
        for (int d = 0; d < 2; d++) begin
            ep[d] = 1'b0;
            if (mode[d] == 1) begin
                cnt[d] = (cnt[d] < 255) ? cnt[d] + 1 : 255;
                e_wvs[d]++;
                e_wr[d] = v;
                ep[d] = ack_en && ((m_max[d] == 0) || (cnt[d] <= m_max[d]));
            end
        end
        bit_out(1'b1, ep, "wack");
    endtask

    task automatic recv_data(input logic [7:0] v, input logic mack);
        for (int i = 7; i >= 0; i--) bit_out(v[i], 2'b00, "rbit");
        bit_out(mack, 2'b00, "rack");
        for (int d = 0; d < 2; d++) begin
            if (mode[d] == 2 && mack) mode[d] = 0;
        end
    endtask

    initial begin
        logic [1:0] ep;
        logic       bus_idle;
        m_mask[0] = 7'h7F;
        m_mask[1] = 7'h7E;
        m_max[0] = 0;
        m_max[1] = 2;
        model_reset();

        wclk(3);
        for (int d = 0; d < 2; d++) check_eq($sformatf("rst/pull%0d", d), pull[d], 1'b0);
        reset_n = 1'b1;
        check_all("reset");

        // Write 0x50: 0x12, 0x34.
        do_start();
        send_addr(7'h50, 1'b0);
        send_data(8'h12);
        send_data(8'h34);
        do_stop("wr50");

        // 0x51: only the masked target answers.
        do_start();
        send_addr(7'h51, 1'b0);
        send_data(8'h55);
        do_stop("wr51");

        // Read 0x50 with ACK, ACK, NACK.
        do_start();
        send_addr(7'h50, 1'b1);
        recv_data(8'hA5, 1'b0);
        recv_data(8'h3C, 1'b0);
        recv_data(8'hF0, 1'b1);
        do_stop("rd50");

        // Byte limit on dut1.
        do_start();
        send_addr(7'h50, 1'b0);
        send_data(8'hAA);
        send_data(8'hBB);
        send_data(8'hCC);
        do_stop("limit");

        // Repeated START from write into read.
        do_start();
        send_addr(7'h50, 1'b0);
        send_data(8'h77);
        do_start();
        send_addr(7'h50, 1'b1);
        recv_data(8'h11, 1'b1);
        do_stop("rstart");

        // Suspended target.
        ack_en = 1'b0;
        do_start();
        send_addr(7'h50, 1'b0);
        send_data(8'h99);
        do_stop("suspend");
        ack_en = 1'b1;

        // Reset in the address ACK slot releases SDA without a clock edge.
        do_start();
        addr_phase(7'h50, 1'b0, ep);
        wclk(Q);
        sda = 1'b1;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        check_eq("rstack/pre_pull0", pull[0], ep[0]);
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check_eq($sformatf("rstack/pull%0d", d), pull[d], 1'b0);
        wclk(2);
        reset_n = 1'b1;
        model_reset();
        wclk(Q);
        scl = 1'b0;
        do_stop("rstack");

`ifdef I2C_ACK_GEN_FILTER_EN
        // A one-clock SCL glitch must not shift the address.
        do_start();
        wclk(Q);
        scl = 1'b1;
        wclk(1);
        scl = 1'b0;
        send_addr(7'h50, 1'b0);
        send_data(8'h5A);
        do_stop("glitch");
`endif

        // Randomised transactions.
        bus_idle = 1'b1;
        for (int t = 0; t < 24; t++) begin
            int         n;
            logic [6:0] a;
            logic       r;
            if (bus_idle) ack_en = ($urandom_range(0, 5) != 0);
            do_start();
            case ($urandom_range(0, 4))
                0:       a = 7'h50;
                1:       a = 7'h51;
                2:       a = 7'h52;
                3:       a = 7'h53;
                default: a = 7'($urandom);
            endcase
            r = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 4);
            send_addr(a, r);
            for (int i = 0; i < n; i++) begin
                if (!r) send_data(8'($urandom));
                else recv_data(8'($urandom), (i == n - 1) || ($urandom_range(0, 3) == 0));
            end
            if ($urandom_range(0, 2) != 0) begin
                do_stop("rand");
                bus_idle = 1'b1;
            end else begin
                bus_idle = 1'b0;
            end
        end
        if (!bus_idle) do_stop("rand_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
